// File: rtl/cpu_pipeline.sv
// Three-stage (IS/EX/WB) execute core with optional EX/WB bypass or RAW interlock,
// EBREAK drain-and-halt, and a wrapping retired-instruction counter.
module cpu_pipeline #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int FORWARD  = 1,
    parameter int RETIRE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                op,
    input  logic [$clog2(NREGS)-1:0]  dst,
    input  logic [$clog2(NREGS)-1:0]  src1,
    input  logic [$clog2(NREGS)-1:0]  src2,
    input  logic                      has_immediate,
    input  logic [XLEN-1:0]           imm,
    input  logic                      ebreak,
    output logic                      wb_valid,
    output logic [$clog2(NREGS)-1:0]  wb_dst,
    output logic [XLEN-1:0]           wb_data,
    output logic                      halted,
    output logic [RETIRE_W-1:0]       retired,
    input  logic [$clog2(NREGS)-1:0]  dbg_addr,
    output logic [XLEN-1:0]           dbg_data
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]          state_q, state_d;
    // vld_pipe_q[1] = EX valid, vld_pipe_q[2] = WB valid
    logic [2:1]          vld_pipe_q;
    logic [3:0]          ex_op_q;
    logic [AW-1:0]       ex_dst_q, wb_dst_q;
    logic [XLEN-1:0]     ex_a_q, ex_b_q, wb_res_q;
    logic                ex_eb_q, wb_eb_q;
    logic [XLEN-1:0]     regs_q [NREGS];
    logic [RETIRE_W-1:0] retired_q;

    logic [XLEN-1:0]     ex_res, op_a, op_b;
    logic [SW-1:0]       shamt;
    logic                ex_fwd, wb_wr, stall, accept;

    assign ex_fwd = vld_pipe_q[1] && !ex_eb_q && (ex_dst_q != '0);
    assign wb_wr  = vld_pipe_q[2] && !wb_eb_q && (wb_dst_q != '0);
    assign shamt  = ex_b_q[SW-1:0];

    always_comb begin
        ex_res = '0;
        case (ex_op_q)
            OP_ADD:  ex_res = ex_a_q + ex_b_q;
            OP_SUB:  ex_res = ex_a_q - ex_b_q;
            OP_AND:  ex_res = ex_a_q & ex_b_q;
            OP_OR:   ex_res = ex_a_q | ex_b_q;
            OP_XOR:  ex_res = ex_a_q ^ ex_b_q;
            OP_SLL:  ex_res = ex_a_q << shamt;
            OP_SRL:  ex_res = ex_a_q >> shamt;
            OP_SRA:  ex_res = $signed(ex_a_q) >>> shamt;
            OP_SLT:  ex_res[0] = $signed(ex_a_q) < $signed(ex_b_q);
            OP_SLTU: ex_res[0] = ex_a_q < ex_b_q;
            default: ex_res = '0;
        endcase
    end

    // Younger producer wins: EX result shadows WB data for the same register.
    function automatic logic [XLEN-1:0] rd_op(input logic [AW-1:0] s);
        if (FORWARD != 0 && ex_fwd && ex_dst_q == s)
            return ex_res;
        if (FORWARD != 0 && wb_wr && wb_dst_q == s)
            return wb_res_q;
        if (s == '0)
            return '0;
        return regs_q[s];
    endfunction

    function automatic logic hz(input logic [AW-1:0] s);
        return (ex_fwd && ex_dst_q == s) || (wb_wr && wb_dst_q == s);
    endfunction

    always_comb begin
        op_a  = rd_op(src1);
        op_b  = has_immediate ? imm : rd_op(src2);
        stall = 1'b0;
        if (FORWARD == 0 && !ebreak)
            stall = hz(src1) || (!has_immediate && hz(src2));
    end

    assign in_ready = (state_q == S_RUN) && !stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (accept && ebreak) state_d = S_DRAIN;
            S_DRAIN: if (vld_pipe_q[2] && wb_eb_q) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            vld_pipe_q <= '0;
            ex_op_q    <= '0;
            ex_dst_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_eb_q    <= 1'b0;
            wb_dst_q   <= '0;
            wb_res_q   <= '0;
            wb_eb_q    <= 1'b0;
            retired_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            vld_pipe_q <= {vld_pipe_q[1], accept};
            if (accept) begin
                ex_op_q  <= op;
                ex_dst_q <= dst;
                ex_a_q   <= op_a;
                ex_b_q   <= op_b;
                ex_eb_q  <= ebreak;
            end
            wb_dst_q <= ex_dst_q;
            wb_res_q <= ex_res;
            wb_eb_q  <= ex_eb_q;
            if (wb_wr)
                regs_q[wb_dst_q] <= wb_res_q;
            if (vld_pipe_q[2] && !wb_eb_q)
                retired_q <= retired_q + 1'b1;
        end
    end

    assign wb_valid = vld_pipe_q[2] && !wb_eb_q;
    assign wb_dst   = wb_dst_q;
    assign wb_data  = wb_res_q;
    assign halted   = (state_q == S_HALT);
    assign retired  = retired_q;
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
endmodule

// File: tb/tb_cpu_pipeline.sv
// Directed checks of cpu_pipeline in bypass, interlock and narrow-width builds.
module tb_cpu_pipeline;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4;
    localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst = 1'b1;
    logic [3:0]  op = '0;
    logic [4:0]  dst = '0, src1 = '0, src2 = '0, dbga = '0;
    logic        himm = 1'b0, eb = 1'b0;
    logic [31:0] imm = '0;
    logic        iv_f = 1'b0, iv_i = 1'b0, iv_n = 1'b0;

    logic        rdy_f, rdy_i, rdy_n, hlt_f, hlt_i, hlt_n, wbv_f, wbv_i, wbv_n;
    logic [4:0]  wbd_f, wbd_i, wbd_n;
    logic [31:0] wdat_f, wdat_i, ret_f, ret_i, dbg_f, dbg_i;
    logic [15:0] wdat_n, dbg_n;
    logic [2:0]  ret_n;

    cpu_pipeline #(.XLEN(32), .NREGS(32), .FORWARD(1), .RETIRE_W(32)) u_fwd (
        .clk(clk), .rst(rst), .in_valid(iv_f), .in_ready(rdy_f), .op(op), .dst(dst),
        .src1(src1), .src2(src2), .has_immediate(himm), .imm(imm), .ebreak(eb),
        .wb_valid(wbv_f), .wb_dst(wbd_f), .wb_data(wdat_f), .halted(hlt_f),
        .retired(ret_f), .dbg_addr(dbga), .dbg_data(dbg_f));

    cpu_pipeline #(.XLEN(32), .NREGS(32), .FORWARD(0), .RETIRE_W(32)) u_ilk (
        .clk(clk), .rst(rst), .in_valid(iv_i), .in_ready(rdy_i), .op(op), .dst(dst),
        .src1(src1), .src2(src2), .has_immediate(himm), .imm(imm), .ebreak(eb),
        .wb_valid(wbv_i), .wb_dst(wbd_i), .wb_data(wdat_i), .halted(hlt_i),
        .retired(ret_i), .dbg_addr(dbga), .dbg_data(dbg_i));

    cpu_pipeline #(.XLEN(16), .NREGS(32), .FORWARD(1), .RETIRE_W(3)) u_nar (
        .clk(clk), .rst(rst), .in_valid(iv_n), .in_ready(rdy_n), .op(op), .dst(dst),
        .src1(src1), .src2(src2), .has_immediate(himm), .imm(imm[15:0]), .ebreak(eb),
        .wb_valid(wbv_n), .wb_dst(wbd_n), .wb_data(wdat_n), .halted(hlt_n),
        .retired(ret_n), .dbg_addr(dbga), .dbg_data(dbg_n));

    int errs = 0, nchk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? rdy_f : (s == 1) ? rdy_i : rdy_n;
    endfunction
    function automatic logic hlt(input int s);
        return (s == 0) ? hlt_f : (s == 1) ? hlt_i : hlt_n;
    endfunction
    function automatic logic wbv(input int s);
        return (s == 0) ? wbv_f : (s == 1) ? wbv_i : wbv_n;
    endfunction
    function automatic logic [4:0] wbd(input int s);
        return (s == 0) ? wbd_f : (s == 1) ? wbd_i : wbd_n;
    endfunction
    function automatic logic [31:0] wdat(input int s);
        return (s == 0) ? wdat_f : (s == 1) ? wdat_i : {16'h0, wdat_n};
    endfunction
    function automatic logic [31:0] ret(input int s);
        return (s == 0) ? ret_f : (s == 1) ? ret_i : {29'h0, ret_n};
    endfunction

    task automatic set_iv(input int s, input logic v);
        case (s)
            0: iv_f = v;
            1: iv_i = v;
            default: iv_n = v;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iv_f = 1'b0; iv_i = 1'b0; iv_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the cycle count of the accepting edge, or -1 after a bounded wait.
    task automatic issue(input int s, input logic [3:0] o, input int d, input int a, input int b,
                         input logic hi, input logic [31:0] im, input logic e, output int ae);
        logic r;
        ae = -1;
        @(negedge clk);
        op = o; dst = d[4:0]; src1 = a[4:0]; src2 = b[4:0]; himm = hi; imm = im; eb = e;
        set_iv(s, 1'b1);
        for (int t = 0; t < 20; t++) begin
            if (t > 0) @(negedge clk);
            #1 r = rdy(s);
            @(posedge clk);
            #1;
            if (r) begin
                ae = cyc;
                break;
            end
        end
        set_iv(s, 1'b0);
        if (ae < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic addi(input int s, input int d, input int a, input logic [31:0] im, output int ae);
        issue(s, ADD, d, a, 0, 1'b1, im, 1'b0, ae);
    endtask
    task automatic rr(input int s, input logic [3:0] o, input int d, input int a, input int b, output int ae);
        issue(s, o, d, a, b, 1'b0, 32'h0, 1'b0, ae);
    endtask
    task automatic ebrk(input int s, output int ae);
        issue(s, ADD, 0, 0, 0, 1'b0, 32'h0, 1'b1, ae);
    endtask

    task automatic rdreg(input int s, input int a, output logic [31:0] v);
        dbga = a[4:0];
        #1;
        v = (s == 0) ? dbg_f : (s == 1) ? dbg_i : {16'h0, dbg_n};
    endtask

    task automatic wait_halt(input int s, output int he);
        he = -1;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk);
            #1;
            if (hlt(s)) begin
                he = cyc;
                break;
            end
        end
    endtask

    // The shared chain program; ofs holds expected acceptance offsets from the first.
    task automatic chain(input int s, input int ofs [7], input int hofs);
        int e [7];
        int he;
        logic [31:0] v;
        addi(s, 1, 0, 10, e[0]);
        addi(s, 1, 1, 40, e[1]);
        addi(s, 2, 1, 10, e[2]);
        addi(s, 3, 2, 1, e[3]);
        addi(s, 4, 3, 1, e[4]);
        rr(s, SUB, 5, 4, 1, e[5]);
        ebrk(s, e[6]);
        for (int i = 1; i < 7; i++) chk($sformatf("chain%0d_acc%0d", s, i), e[i] - e[0], ofs[i]);
        wait_halt(s, he);
        chk($sformatf("chain%0d_halt_edge", s), he - e[0], hofs);
        chk($sformatf("chain%0d_rdy_halted", s), {31'h0, rdy(s)}, 32'd0);
        rdreg(s, 1, v); chk("chain_x1", v, 32'd50);
        rdreg(s, 2, v); chk("chain_x2", v, 32'd60);
        rdreg(s, 3, v); chk("chain_x3", v, 32'd61);
        rdreg(s, 4, v); chk("chain_x4", v, 32'd62);
        rdreg(s, 5, v); chk("chain_x5", v, 32'd12);
        chk($sformatf("chain%0d_retired", s), ret(s), 32'd6);
    endtask

    task automatic x0_and_bubble(input int s);
        int a0, a1;
        logic [31:0] v;
        do_reset();
        addi(s, 6, 0, 9, a0);
        addi(s, 0, 0, 5, a0);
        rr(s, ADD, 6, 0, 0, a1);
        chk($sformatf("x0_nostall%0d", s), a1 - a0, 32'd1);
        idle(3);
        rdreg(s, 6, v); chk("x0_x6", v, 32'd0);
        rdreg(s, 0, v); chk("x0_x0", v, 32'd0);
        addi(s, 1, 0, 7, a0);
        @(posedge clk);
        #1;
        chk("bub_wb_valid", {31'h0, wbv(s)}, 32'd1);
        chk("bub_wb_dst", {27'h0, wbd(s)}, 32'd1);
        chk("bub_wb_data", wdat(s), 32'd7);
        idle(1);
        addi(s, 2, 1, 1, a1);
        chk($sformatf("bub_acc%0d", s), a1 - a0, 32'd3);
        idle(3);
        rdreg(s, 2, v); chk("bub_x2", v, 32'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2;
        int ofs_f [7] = '{0, 1, 2, 3, 4, 5, 6};
        int ofs_i [7] = '{0, 3, 6, 9, 12, 15, 16};
        logic [3:0]  t_op  [10] = '{AND, OR, XOR, SLL, SRL, SRA, SRL, SLT, SLTU, SUB};
        int          t_s1  [10] = '{1, 1, 1, 1, 1, 9, 9, 9, 9, 1};
        int          t_s2  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 9};
        logic        t_hi  [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        logic [31:0] t_imm [10] = '{32'h3C, 32'h0C, 32'hFF, 32'd36, 32'd4, 32'd2, 32'd28, 0, 0, 0};
        logic [31:0] t_exp [10] = '{32'h30, 32'hFC, 32'h0F, 32'hF00, 32'h0F,
                                    32'hFFFF_FFFC, 32'hF, 32'd1, 32'd0, 32'h100};
        logic [31:0] v;

        do_reset();
        chk("rst_in_ready", {31'h0, rdy_f}, 32'd1);
        chk("rst_halted", {31'h0, hlt_f}, 32'd0);
        chk("rst_wb_valid", {31'h0, wbv_f}, 32'd0);
        chk("rst_retired", ret_f, 32'd0);
        rdreg(0, 1, v); chk("rst_x1", v, 32'd0);

        chain(0, ofs_f, 8);
        do_reset();
        chain(1, ofs_i, 18);

        x0_and_bubble(0);
        x0_and_bubble(1);

        // Immediate form must not interlock on src2; register form must.
        addi(1, 7, 0, 3, a0);
        issue(1, ADD, 3, 0, 7, 1'b1, 32'd1, 1'b0, a1);
        rr(1, ADD, 4, 0, 7, a2);
        chk("ilk_imm_nostall", a1 - a0, 32'd1);
        chk("ilk_src2_stall", a2 - a0, 32'd3);
        idle(3);
        rdreg(1, 3, v); chk("ilk_x3", v, 32'd1);
        rdreg(1, 4, v); chk("ilk_x4", v, 32'd3);

        addi(0, 1, 0, 32'hF0, a0);
        addi(0, 9, 0, -16, a0);
        for (int i = 0; i < 10; i++) issue(0, t_op[i], 10 + i, t_s1[i], t_s2[i], t_hi[i], t_imm[i], 1'b0, a0);
        idle(3);
        for (int i = 0; i < 10; i++) begin
            rdreg(0, 10 + i, v);
            chk($sformatf("alu%0d", i), v, t_exp[i]);
        end

        ebrk(0, a0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        chk("rdrain_halted", {31'h0, hlt_f}, 32'd0);
        chk("rdrain_in_ready", {31'h0, rdy_f}, 32'd1);
        chk("rdrain_retired", ret_f, 32'd0);
        chk("rdrain_wb_valid", {31'h0, wbv_f}, 32'd0);
        rdreg(0, 1, v);  chk("rdrain_x1", v, 32'd0);
        rdreg(0, 10, v); chk("rdrain_x10", v, 32'd0);
        rdreg(0, 19, v); chk("rdrain_x19", v, 32'd0);

        do_reset();
        addi(2, 1, 0, 32'hFFFF_FFFF, a0);
        addi(2, 1, 1, 32'd1, a0);
        chk("nar_wb_ffff", wdat(2), 32'h0000_FFFF);
        for (int i = 0; i < 7; i++) addi(2, 2, 0, i, a0);
        idle(3);
        rdreg(2, 1, v); chk("nar_x1_wrap", v, 32'd0);
        chk("nar_retired_wrap", ret(2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
